// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths and control-strobe indices for the restoring divider
package div_pkg;

    localparam int N  = 9;
    localparam int CW = 4;

    // Bit positions of the controller strobes when packed into one word
    localparam int CTRL_LOADA  = 0;
    localparam int CTRL_LOADM  = 1;
    localparam int CTRL_LOADQ  = 2;
    localparam int CTRL_PQ     = 3;
    localparam int CTRL_PA     = 4;
    localparam int CTRL_INITA0 = 5;
    localparam int CTRL_INIT   = 6;
    localparam int CTRL_SHIFT  = 7;
    localparam int CTRL_DEC    = 8;
    localparam int CTRL_W      = 9;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // One-hot strobe word with only the given index set
    function automatic ctrl_t ctrl_bit(input int idx);
        return ctrl_t'(1) << idx;
    endfunction

endpackage

// File: rtl/div_datapath_if.sv
// rtl/div_datapath_if.sv - controller/datapath strobe and status bundle (DIVIDER_DIVZERO_FLAG_EN adds divzero)
interface div_datapath_if;
    import div_pkg::*;

    logic          loadA;
    logic          loadM;
    logic          loadQ;
    logic          PQ;
    logic          PA;
    logic          initA0;
    logic          init_counter;
    logic          shift;
    logic          dec_counter;
    logic [N-1:0]  Abus;
    logic [N-1:0]  Bbus;
    logic [N-1:0]  Qbus;
    logic [N-1:0]  Rbus;
    logic [CW-1:0] count;
    logic          signbit;
`ifdef DIVIDER_DIVZERO_FLAG_EN
    logic          divzero;
`endif

    // Controller side: drives strobes and operands, observes status
    modport master (
        output loadA, loadM, loadQ, PQ, PA, initA0, init_counter, shift, dec_counter,
        output Abus, Bbus,
        input  Qbus, Rbus, count, signbit
`ifdef DIVIDER_DIVZERO_FLAG_EN
        , input divzero
`endif
    );

    // Datapath side
    modport slave (
        input  loadA, loadM, loadQ, PQ, PA, initA0, init_counter, shift, dec_counter,
        input  Abus, Bbus,
        output Qbus, Rbus, count, signbit
`ifdef DIVIDER_DIVZERO_FLAG_EN
        , output divzero
`endif
    );

endinterface

// File: rtl/div_counter.sv
// rtl/div_counter.sv - loadable iteration counter that saturates at zero
module div_counter
    import div_pkg::*;
#(
    parameter int LOAD = N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          dec,
    output logic [CW-1:0] count
);

    // Load wins over decrement; decrement stops at zero instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (init) begin
            count <= CW'(LOAD);
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/div_datapath.sv
// rtl/div_datapath.sv - restoring divider registers and trial subtractor (DIVIDER_DIVZERO_FLAG_EN adds divzero)
module div_datapath
    import div_pkg::*;
(
    input logic           clk,
    input logic           rst,
    div_datapath_if.slave bus
);

    // A is one bit wider than M: a shifted partial remainder reaches 2M-1
    logic [N:0]   a_reg;
    logic [N-1:0] q_reg;
    logic [N-1:0] m_reg;
    logic [N:0]   diff;

    assign diff        = a_reg - {1'b0, m_reg};
    assign bus.signbit = diff[N];
    assign bus.Qbus    = q_reg;
    assign bus.Rbus    = a_reg[N-1:0];

    // Partial remainder: clear, shift in Q's MSB, unconditional or restoring load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= '0;
        end else if (bus.initA0) begin
            a_reg <= '0;
        end else if (bus.shift) begin
            a_reg <= {a_reg[N-1:0], q_reg[N-1]};
        end else if (bus.loadA) begin
            a_reg <= diff;
        end else if (bus.PA && !diff[N]) begin
            a_reg <= diff;
        end
    end

    // Dividend/quotient: load, shift left, or record the trial outcome in bit 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (bus.loadQ) begin
            q_reg <= bus.Abus;
        end else if (bus.shift) begin
            q_reg <= {q_reg[N-2:0], 1'b0};
        end else if (bus.PQ) begin
            q_reg[0] <= ~diff[N];
        end
    end

    // Divisor register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reg <= '0;
        end else if (bus.loadM) begin
            m_reg <= bus.Bbus;
        end
    end

    div_counter #(.LOAD(N)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .init  (bus.init_counter),
        .dec   (bus.dec_counter),
        .count (bus.count)
    );

`ifdef DIVIDER_DIVZERO_FLAG_EN
    logic m_loaded;

    // Remembers whether a divisor has been loaded since reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_loaded <= 1'b0;
        end else if (bus.loadM) begin
            m_loaded <= 1'b1;
        end
    end

    // Suppress the M==0 indication for the untouched post-reset register
    assign bus.divzero = (m_reg == '0) && !((bus.count == '0) && !m_loaded);
`endif

endmodule

// File: tb/tb_div_datapath.sv
// tb/tb_div_datapath.sv - self-checking bench for div_datapath
module tb_div_datapath;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_datapath_if bus();

    div_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ctrl(input ctrl_t c);
        bus.loadA        = c[CTRL_LOADA];
        bus.loadM        = c[CTRL_LOADM];
        bus.loadQ        = c[CTRL_LOADQ];
        bus.PQ           = c[CTRL_PQ];
        bus.PA           = c[CTRL_PA];
        bus.initA0       = c[CTRL_INITA0];
        bus.init_counter = c[CTRL_INIT];
        bus.shift        = c[CTRL_SHIFT];
        bus.dec_counter  = c[CTRL_DEC];
    endtask

    // Called at a falling edge: hold strobes across one rising edge, sample at the next falling edge
    task automatic apply(input ctrl_t c);
        set_ctrl(c);
        @(negedge clk);
        set_ctrl('0);
    endtask

    task automatic load_operands(input int a, input int b);
        bus.Abus = N'(a);
        bus.Bbus = N'(b);
        apply(ctrl_bit(CTRL_INITA0) | ctrl_bit(CTRL_INIT));
        apply(ctrl_bit(CTRL_LOADQ) | ctrl_bit(CTRL_LOADM));
    endtask

    // Loop until the counter reports done, bounded so a stuck counter cannot hang the run
    task automatic run_loop(input string tag, input int expected_iters);
        int iters = 0;
        while (bus.count != '0 && iters < 16) begin
            apply(ctrl_bit(CTRL_SHIFT));
            apply(ctrl_bit(CTRL_PA) | ctrl_bit(CTRL_PQ));
            apply(ctrl_bit(CTRL_DEC));
            iters++;
        end
        check({tag, " iterations"}, iters, expected_iters);
    endtask

    task automatic divide_and_check(input string tag, input int a, input int b, input int q, input int r);
        load_operands(a, b);
        run_loop(tag, N);
        check({tag, " Qbus"}, bus.Qbus, q);
        check({tag, " Rbus"}, bus.Rbus, r);
        check({tag, " count"}, bus.count, 0);
    endtask

    initial begin
        int a;
        int b;
        int a_model;

        vecs[0] = '{11, 3, 3, 2};
        vecs[1] = '{511, 1, 511, 0};
        vecs[2] = '{5, 7, 0, 5};
        vecs[3] = '{0, 5, 0, 0};
        vecs[4] = '{511, 511, 1, 0};
        vecs[5] = '{256, 255, 1, 1};
        vecs[6] = '{510, 2, 255, 0};

        rst = 1'b0;
        set_ctrl('0);
        bus.Abus = '0;
        bus.Bbus = '0;
        #1;
        check("reset Qbus", bus.Qbus, 0);
        check("reset Rbus", bus.Rbus, 0);
        check("reset count", bus.count, 0);
        check("reset signbit", bus.signbit, 0);
`ifdef DIVIDER_DIVZERO_FLAG_EN
        check("reset divzero", bus.divzero, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Load 11/3 and step one iteration by hand
        load_operands(11, 3);
        check("load Qbus", bus.Qbus, 11);
        check("load Rbus", bus.Rbus, 0);
        check("load count", bus.count, 9);
        check("load signbit", bus.signbit, 1);
`ifdef DIVIDER_DIVZERO_FLAG_EN
        check("divzero M=3", bus.divzero, 0);
`endif
        apply(ctrl_bit(CTRL_SHIFT));
        check("step shift Qbus", bus.Qbus, 22);
        check("step shift Rbus", bus.Rbus, 0);
        apply(ctrl_bit(CTRL_PA) | ctrl_bit(CTRL_PQ));
        check("step commit Rbus", bus.Rbus, 0);
        check("step commit Qbus", bus.Qbus, 22);
        apply(ctrl_bit(CTRL_DEC));
        check("step dec count", bus.count, 8);
        run_loop("11/3 rest", 8);
        check("11/3 Qbus", bus.Qbus, 3);
        check("11/3 Rbus", bus.Rbus, 2);
        check("11/3 count", bus.count, 0);

        // Unconditional loadA: A=2, M=3, A becomes (2-3) mod 2^(N+1)
        a_model = (2 - 3 + (1 << (N + 1))) % (1 << (N + 1));
        apply(ctrl_bit(CTRL_LOADA));
        check("loadA Rbus", bus.Rbus, a_model % (1 << N));
        check("loadA signbit", bus.signbit, ((a_model - 3) < 0) ? 0 : (((a_model - 3) >> N) & 1));
        apply(ctrl_bit(CTRL_INITA0) | ctrl_bit(CTRL_LOADA));
        check("initA0+loadA Rbus", bus.Rbus, 0);
        check("initA0+loadA signbit", bus.signbit, 1);

        // Counter boundaries
        apply(ctrl_bit(CTRL_INIT));
        for (int i = 0; i < 12; i++) apply(ctrl_bit(CTRL_DEC));
        check("dec saturate count", bus.count, 0);
        apply(ctrl_bit(CTRL_INIT) | ctrl_bit(CTRL_DEC));
        check("init+dec count", bus.count, 9);
        apply(ctrl_bit(CTRL_DEC));
        check("dec after init count", bus.count, 8);

`ifdef DIVIDER_DIVZERO_FLAG_EN
        bus.Bbus = '0;
        apply(ctrl_bit(CTRL_LOADM));
        check("divzero M=0", bus.divzero, 1);
`endif

        // Asynchronous reset in the middle of a division
        load_operands(100, 7);
        apply(ctrl_bit(CTRL_SHIFT));
        apply(ctrl_bit(CTRL_PA) | ctrl_bit(CTRL_PQ));
        #2;
        rst = 1'b0;
        #1;
        check("midreset Qbus", bus.Qbus, 0);
        check("midreset Rbus", bus.Rbus, 0);
        check("midreset count", bus.count, 0);
        check("midreset signbit", bus.signbit, 0);
        #1;
        rst = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            divide_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
        end

        // Random operands against integer division
        for (int i = 0; i < 25; i++) begin
            a = int'($urandom_range(0, (1 << N) - 1));
            b = int'($urandom_range(1, (1 << N) - 1));
            divide_and_check($sformatf("rand%0d %0d/%0d", i, a, b), a, b, a / b, a % b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
